// File: rtl/jump_label_writer.sv
// Run-time loaded 16-entry jump-label table with valid/ready write port and 1-cycle lookup.
// Optional macro JUMP_LABEL_BOOT_TABLE_EN: reset preloads a boot table and starts in READY.
module jump_label_writer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_target,
  input  logic              wr_last,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_target,
  output logic              rd_miss,
  output logic              busy,
  output logic              dup_err
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, READY} state_e;

`ifdef JUMP_LABEL_BOOT_TABLE_EN
  localparam state_e           RESET_STATE = READY;
  localparam logic [DEPTH-1:0] RESET_VALID = DEPTH'(9'h1FF);

  function automatic logic [ADDR_W-1:0] boot_entry(input int unsigned i);
    logic [ADDR_W-1:0] v;
    v = '0;
    case (i)
      0:       v = ADDR_W'(9);
      1:       v = ADDR_W'(19);
      2:       v = ADDR_W'(76);
      3:       v = ADDR_W'(101);
      4:       v = ADDR_W'(123);
      5:       v = ADDR_W'(131);
      6:       v = ADDR_W'(8);
      7:       v = ADDR_W'(37);
      8:       v = ADDR_W'(16);
      default: v = '0;
    endcase
    return v;
  endfunction
`else
  localparam state_e           RESET_STATE = IDLE;
  localparam logic [DEPTH-1:0] RESET_VALID = '0;
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic              busy_q, busy_d;
  logic              wr_ready_q, wr_ready_d;
  logic              dup_err_q, dup_err_d;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] rd_target_q;
  logic              rd_miss_q;
  logic              wr_fire;
  logic              rd_hit;

  assign wr_fire = wr_valid && wr_ready_q;
  assign rd_hit  = (state_q == READY) && valid_q[rd_idx];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic; the clear counter wraps to 0 as CLEAR hands over to LOAD
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    case (state_q)
      IDLE:  if (load_start) state_d = CLEAR;
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = LOAD;
      end
      LOAD:  if (wr_fire && wr_last) state_d = READY;
      READY: if (load_start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Output logic, decoded from the next state so the registered outputs track state_q
  always_comb begin
    busy_d     = (state_d == CLEAR) || (state_d == LOAD);
    wr_ready_d = (state_d == LOAD);
    dup_err_d  = dup_err_q;
    if (state_q != CLEAR && state_d == CLEAR) begin
      dup_err_d = 1'b0;
    end else if (wr_fire && valid_q[wr_idx]) begin
      dup_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      dup_err_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
      dup_err_q  <= dup_err_d;
    end
  end

  // Label table: CLEAR only drops valid bits, stale targets are never visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef JUMP_LABEL_BOOT_TABLE_EN
        entry_q[IDX_W'(i)] <= boot_entry(i);
`else
        entry_q[IDX_W'(i)] <= '0;
`endif
      end
      valid_q <= RESET_VALID;
    end else begin
      if (state_q == CLEAR) valid_q[clr_cnt_q] <= 1'b0;
      if (wr_fire) begin
        entry_q[wr_idx] <= wr_target;
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Lookup port; result fields hold when no request is made
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      rd_target_q <= '0;
      rd_miss_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_target_q <= rd_hit ? entry_q[rd_idx] : '0;
        rd_miss_q   <= !rd_hit;
      end
    end
  end

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign dup_err   = dup_err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_target = rd_target_q;
  assign rd_miss   = rd_miss_q;

endmodule
